fp_spl_case_pipe: RTL
=====================

FP_SPL_CASE_PIPE -- requirements
Module: fp_spl_case_pipe

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width, legal range 2..15.
REQ-002 Parameter MAN_W, default 23: mantissa field width, legal range 2..112.
REQ-003 Derived width W = 1+EXP_W+MAN_W: sign at bit W-1, exponent at [W-2:MAN_W], mantissa at [MAN_W-1:0].
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1: operand pair a/b/op presented.
REQ-007 Port in_ready, output, 1: block accepts input this cycle.
REQ-008 Port a, input, W: operand A.
REQ-009 Port b, input, W: operand B.
REQ-010 Port op, input, 1: 0 selects A+B, 1 selects A-B.
REQ-011 Port out_valid, output, 1: result/spl_case valid.
REQ-012 Port out_ready, input, 1: downstream accepts output.
REQ-013 Port spl_case, output, 1: the operation is a special case resolved here.
REQ-014 Port result, output, W: special-case result; all zeros when spl_case=0.
REQ-015 Port flag_invalid, output, 1: sticky IEEE invalid-operation flag.
REQ-016 Port flag_clr, input, 1: clears flag_invalid.

Function
REQ-017 Transfer on in_valid&in_ready (input) and out_valid&out_ready (output); order preserved, no loss, no duplication.
REQ-018 Two register stages: S1 classifies, S2 resolves. Latency is exactly 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 per cycle.
REQ-019 S2 loads when !S2.valid or out_ready. S1 advances under the same condition. in_ready = !S1.valid or S1 advancing. in_ready has no combinational path from in_valid.
REQ-020 Effective B sign is b[W-1]^op; all rules below use the effective B sign.
REQ-021 Classification uses only the exponent and mantissa fields. NaN: exponent all ones, mantissa nonzero. Inf: exponent all ones, mantissa zero. Zero: exponent zero, mantissa zero. sNaN: NaN with mantissa MSB = 0.
REQ-022 Priority 1: either operand is NaN. result = canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, other bits 0), spl_case=1.
REQ-023 Priority 2: both operands Inf. If signs are equal, result = A. If signs differ, result = canonical qNaN. spl_case=1 in both cases.
REQ-024 Priority 3: exactly one operand Inf. result = that Inf with its own effective sign, spl_case=1.
REQ-025 Priority 4: both operands zero. result = zero with sign = A.sign & effB.sign, spl_case=1.
REQ-026 Priority 5: exactly one operand zero. result = the other operand with its effective sign, spl_case=1.
REQ-027 Otherwise: spl_case=0, result=0.
REQ-028 flag_invalid is set when a transaction loads into S2 and that transaction is Inf−Inf with opposite effective signs, or has any sNaN operand.
REQ-029 flag_clr=1 clears flag_invalid on the next edge. If set and clear occur in the same cycle, set wins.
REQ-030 While the output is stalled (out_valid&!out_ready), result, spl_case and out_valid hold stable.

Reset
REQ-031 rst_n low asynchronously clears S1.valid, S2.valid, out_valid, spl_case, result and flag_invalid to 0.
REQ-032 While rst_n is low, in_ready = 0.
REQ-033 The first edge after rst_n rises has in_ready = 1.
REQ-034 Reset asserted mid-stream discards all in-flight transactions; none are emitted after release.

Configuration
REQ-035 Macro FP_SPL_DAZ_EN defined: subnormal operands (exponent zero, mantissa nonzero) are treated as zero of the same sign for REQ-025/026 (denormals-are-zero).
REQ-036 Macro FP_SPL_DAZ_EN undefined: subnormals are ordinary finite values, so spl_case=0 unless another rule applies.

Verification (default parameters)
REQ-037 a=7F800000, b=FF800000, op=0 -> result 7FC00000 two cycles later; spl_case=1; flag_invalid=1. Then flag_clr=1 -> flag_invalid=0.
REQ-038 a=FF800000, b=3F800000, op=0 -> result FF800000, spl_case=1, flag unchanged. a=7F800000, b=7F800000, op=1 -> result 7FC00000, flag_invalid=1.
REQ-039 a=80000000, b=00000000, op=1 -> result 80000000. Same a,b with op=0 -> result 00000000. a=00000000, b=40490FDB, op=1 -> result C0490FDB.
REQ-040 a=7F800001 (sNaN), b=3F800000 -> result 7FC00000, flag_invalid=1. a=3F800000, b=40000000 -> spl_case=0, result 00000000.
REQ-041 Stream 5 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted; on release all 5 outputs in order, no loss. Assert rst_n low mid-stream -> no further out_valid.
REQ-042 a=00000001, b=3F800000, op=0 -> with FP_SPL_DAZ_EN: spl_case=1, result 3F800000; without: spl_case=0. Repeat REQ-037 with EXP_W=5, MAN_W=10: a=7C00, b=FC00 -> result 7E00.

Source files
------------

// File: rtl/fp_spl_case_pipe.sv
// fp_spl_case_pipe: two-stage pipeline that detects and resolves IEEE-754
// add/sub special cases (NaN, Inf, zero operands).
//   S1 registers the operands and their classification.
//   S2 registers the resolved result, spl_case and output valid.
// Optional build macro FP_SPL_DAZ_EN: subnormal operands are treated as
// zeros of the same sign (denormals-are-zero). Undefined by default.
module fp_spl_case_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   spl_case,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_invalid,
  input  logic                   flag_clr
);

  localparam int W = 1 + EXP_W + MAN_W;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Class vector bit positions.
  localparam int C_NAN  = 3;
  localparam int C_INF  = 2;
  localparam int C_ZERO = 1;
  localparam int C_SNAN = 0;

  // Classify one operand from its exponent and mantissa fields only.
  function automatic logic [3:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] ex;
    logic [MAN_W-1:0] mn;
    logic             ex_ones;
    logic             ex_zero;
    logic             mn_zero;
    logic [3:0]       cls;
    ex      = x[W-2:MAN_W];
    mn      = x[MAN_W-1:0];
    ex_ones = &ex;
    ex_zero = ~|ex;
    mn_zero = ~|mn;
    cls             = 4'b0000;
    cls[C_NAN]      = ex_ones & ~mn_zero;
    cls[C_INF]      = ex_ones & mn_zero;
    cls[C_SNAN]     = ex_ones & ~mn_zero & ~mn[MAN_W-1];
`ifdef FP_SPL_DAZ_EN
    cls[C_ZERO]     = ex_zero;
`else
    cls[C_ZERO]     = ex_zero & mn_zero;
`endif
    return cls;
  endfunction

  // Stage 1 state
  logic           s1_valid_q, s1_valid_d;
  logic [W-1:0]   s1_a_q, s1_a_d;
  logic [W-1:0]   s1_b_q, s1_b_d;     // B with effective sign already applied
  logic [3:0]     s1_cls_a_q, s1_cls_a_d;
  logic [3:0]     s1_cls_b_q, s1_cls_b_d;

  // Stage 2 / output state
  logic           s2_valid_q, s2_valid_d;
  logic [W-1:0]   result_q, result_d;
  logic           spl_case_q, spl_case_d;
  logic           flag_invalid_q, flag_invalid_d;

  // Resolution of the transaction currently held in S1
  logic [W-1:0]   res_c;
  logic           spl_c;
  logic           inv_c;

  logic           s2_adv;
  logic [W-1:0]   b_eff;

  assign s2_adv   = ~s2_valid_q | out_ready;
  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready = rst_n & (~s1_valid_q | s2_adv);
  assign b_eff    = {b[W-1] ^ op, b[W-2:0]};

  // S1 next state: capture operand pair and its classification on input transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d     = a;
        s1_b_d     = b_eff;
        s1_cls_a_d = classify(a);
        s1_cls_b_d = classify(b);
      end
    end
  end

  // Priority-ordered special-case resolution of the S1 contents.
  always_comb begin
    logic sa;
    logic sb;
    sa    = s1_a_q[W-1];
    sb    = s1_b_q[W-1];
    res_c = '0;
    spl_c = 1'b0;
    inv_c = (s1_cls_a_q[C_INF] & s1_cls_b_q[C_INF] & (sa != sb))
          | s1_cls_a_q[C_SNAN] | s1_cls_b_q[C_SNAN];
    if (s1_cls_a_q[C_NAN] | s1_cls_b_q[C_NAN]) begin
      spl_c = 1'b1;
      res_c = QNAN;
    end else if (s1_cls_a_q[C_INF] & s1_cls_b_q[C_INF]) begin
      spl_c = 1'b1;
      res_c = (sa == sb) ? s1_a_q : QNAN;
    end else if (s1_cls_a_q[C_INF]) begin
      spl_c = 1'b1;
      res_c = s1_a_q;
    end else if (s1_cls_b_q[C_INF]) begin
      spl_c = 1'b1;
      res_c = s1_b_q;
    end else if (s1_cls_a_q[C_ZERO] & s1_cls_b_q[C_ZERO]) begin
      spl_c = 1'b1;
      res_c = {sa & sb, {(W-1){1'b0}}};
    end else if (s1_cls_a_q[C_ZERO]) begin
      spl_c = 1'b1;
      res_c = s1_b_q;
    end else if (s1_cls_b_q[C_ZERO]) begin
      spl_c = 1'b1;
      res_c = s1_a_q;
    end
  end

  // S2 next state and sticky invalid flag (set has priority over clear).
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    spl_case_d = spl_case_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      result_d   = s1_valid_q ? res_c : '0;
      spl_case_d = s1_valid_q & spl_c;
    end
    flag_invalid_d = (s2_adv & s1_valid_q & inv_c) | (flag_invalid_q & ~flag_clr);
  end

  // S1 register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cls_a_q <= '0;
      s1_cls_b_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cls_a_q <= s1_cls_a_d;
      s1_cls_b_q <= s1_cls_b_d;
    end
  end

  // S2 / output register and flag with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q     <= 1'b0;
      result_q       <= '0;
      spl_case_q     <= 1'b0;
      flag_invalid_q <= 1'b0;
    end else begin
      s2_valid_q     <= s2_valid_d;
      result_q       <= result_d;
      spl_case_q     <= spl_case_d;
      flag_invalid_q <= flag_invalid_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign result       = result_q;
  assign spl_case     = spl_case_q;
  assign flag_invalid = flag_invalid_q;

endmodule
